// File: rtl/tt_uio_pkg.sv
// tt_uio_pkg: shared state type and uio pin map for the byte transmitter
package tt_uio_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, STB, REL} state_t;
  localparam int NIB_LSB = 0;
  localparam int STB_BIT = 4;
  localparam int ACK_BIT = 5;
  localparam logic [7:0] OE_MASK = 8'h1F;
endpackage

// File: rtl/tt_uio_tx_if.sv
// tt_uio_tx_if: core byte stream, uio pins and status of the transmitter
interface tt_uio_tx_if;
  logic io_in_valid;
  logic io_in_ready;
  logic [7:0] io_in_bits;
  logic [7:0] io_uio_in;
  logic [7:0] io_uio_out;
  logic [7:0] io_uio_oe;
  logic io_busy;
  logic io_err;
  logic io_err_clr;
  modport master (
    output io_in_valid, io_in_bits, io_uio_in, io_err_clr,
    input io_in_ready, io_uio_out, io_uio_oe, io_busy, io_err
  );
  modport slave (
    input io_in_valid, io_in_bits, io_uio_in, io_err_clr,
    output io_in_ready, io_uio_out, io_uio_oe, io_busy, io_err
  );
endinterface

// File: rtl/tt_byte_fifo.sv
// tt_byte_fifo: byte FIFO with ready/valid push, pop strobe and head data
module tt_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_bits,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic full;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr[AW-1:0] == rd_ptr[AW-1:0] && wr_ptr[AW] != rd_ptr[AW];
  assign in_ready = !full;
  assign head = mem[rd_ptr[AW-1:0]];
  // pointers carry an extra wrap bit so full and empty are distinguishable
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (in_valid && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  // storage needs no reset, pointers define what is valid
  always_ff @(posedge clock)
    if (in_valid && !full) mem[wr_ptr[AW-1:0]] <= in_bits;
endmodule

// File: rtl/tt_uio_tx.sv
// tt_uio_tx: byte transmitter over the TinyTapeout uio pins with a 4-phase strobe/ack handshake
module tt_uio_tx
  import tt_uio_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 255
) (
  input logic clock,
  input logic reset,
  tt_uio_tx_if.slave bus
);
  state_t state, state_n;
  logic started, ack_m, ack_s, nib, nib_n, pop, tmo, to_err, fifo_ready, empty, err_q;
  logic [7:0] head, cnt, cnt_n, out_q, out_n;
  logic [3:0] nib_sel;
  tt_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock,
    .reset,
    .in_valid(bus.io_in_valid && started),
    .in_ready(fifo_ready),
    .in_bits(bus.io_in_bits),
    .pop,
    .head,
    .empty
  );
  assign bus.io_in_ready = started && fifo_ready;
  assign bus.io_uio_oe = started ? OE_MASK : 8'h00;
  assign bus.io_uio_out = out_q;
  assign bus.io_busy = !empty || state != IDLE;
  assign bus.io_err = err_q;
  assign tmo = cnt == 8'(TIMEOUT - 1);
  // two-flop ACK synchronizer plus the flag that enables the pins after reset
  always_ff @(posedge clock or posedge reset)
    if (reset) {started, ack_m, ack_s} <= '0;
    else {started, ack_m, ack_s} <= {1'b1, bus.io_uio_in[ACK_BIT], ack_m};
  // handshake sequencing: next state, nibble select, timeout and pop
  always_comb begin
    state_n = state;
    nib_n = nib;
    cnt_n = (state == STB || state == REL) ? cnt + 8'd1 : cnt;
    pop = 1'b0;
    to_err = 1'b0;
    case (state)
      IDLE: if (!empty && !ack_s) begin
        state_n = SETUP;
        nib_n = 1'b1;
      end
      SETUP: begin
        state_n = STB;
        cnt_n = '0;
      end
      STB: if (ack_s) begin
        state_n = REL;
        cnt_n = '0;
      end else if (tmo) begin
        state_n = IDLE;
        pop = 1'b1;
        to_err = 1'b1;
      end
      REL: if (!ack_s) begin
        state_n = nib ? SETUP : IDLE;
        pop = !nib;
        nib_n = 1'b0;
      end else if (tmo) begin
        state_n = IDLE;
        pop = 1'b1;
        to_err = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    nib_sel = nib_n ? head[7:4] : head[3:0];
    out_n = '0;
    if (state_n != IDLE) begin
      out_n[NIB_LSB+:4] = nib_sel;
      out_n[STB_BIT] = state_n == STB;
    end
  end
  // registered FSM state and pin outputs; a timeout beats a same-cycle error clear
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      nib <= 1'b0;
      cnt <= '0;
      out_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      nib <= nib_n;
      cnt <= cnt_n;
      out_q <= out_n;
      err_q <= to_err || (err_q && !bus.io_err_clr);
    end
endmodule
